// File: rtl/io_uart_pkg.sv
// Shared definitions for the IO-bus UART transmitter: register map, STATUS
// bit layout and transmit FSM encoding.
package io_uart_pkg;

  localparam logic [3:0] DATA_OFF   = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue output; pushes while full and pops
// while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Fullness is judged on the pre-edge count, so a push racing a pop on a full FIFO is dropped.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA writes queue bytes, STATUS reports
// busy/full/empty/overflow/count, and a baud-timed FSM drives TXD.
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        io_sel,
  input  logic        io_wr,
  input  logic [3:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        TXD
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);

  tx_state_e     state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          ovf_q;

  logic          wr_data, wr_status, slot_end, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;
  logic          unused_bits;

  assign wr_data   = io_sel & io_wr & (io_addr[3:2] == DATA_OFF[3:2]);
  assign wr_status = io_sel & io_wr & (io_addr[3:2] == STATUS_OFF[3:2]);
  assign slot_end  = (baud_q == SLOT_LAST);
  assign unused_bits = ^{io_wdata[31:8], io_addr[1:0]};

  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == IDLE)                 fifo_pop = 1'b1;
      else if (state_q == STOP && slot_end) fifo_pop = 1'b1;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (wr_data),
    .din_i   (io_wdata[7:0]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ovf_q <= 1'b0;
    end else if (wr_data && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (wr_status && io_wdata[ST_OVF]) begin
      ovf_q <= 1'b0;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_sel && io_addr[3:2] == STATUS_OFF[3:2]) begin
      io_rdata[ST_BUSY]             = (state_q != IDLE);
      io_rdata[ST_FULL]             = fifo_full;
      io_rdata[ST_EMPTY]            = fifo_empty;
      io_rdata[ST_OVF]              = ovf_q;
      io_rdata[ST_CNT_LSB +: AW+1]  = fifo_count;
    end
  end

  // TXD is loaded with the level of the slot being entered, so it changes on slot boundaries only.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            baud_q  <= '0;
            state_q <= START;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (slot_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (slot_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        STOP: begin
          if (slot_end) begin
            baud_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_dout;
              state_q <= START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TXD = txd_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx at DIV=4, FIFO_DEPTH=4; frames are sampled
// mid-slot from the start-bit edge.
module tb_io_uart_tx;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        io_sel = 1'b0;
  logic        io_wr = 1'b0;
  logic [3:0]  io_addr = 4'h0;
  logic [31:0] io_wdata = 32'h0;
  logic [31:0] io_rdata;
  logic        TXD;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  io_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .FIFO_DEPTH(4)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .io_sel   (io_sel),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .TXD      (TXD)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    io_sel = 1'b1; io_wr = 1'b1; io_addr = a; io_wdata = d;
    @(negedge CLK);
    io_sel = 1'b0; io_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    io_sel = 1'b1; io_wr = 1'b0; io_addr = a;
    #1;
    check(tag, io_rdata, exp);
    @(negedge CLK);
    io_sel = 1'b0;
  endtask

  // Entered half a cycle after the start-bit edge; samples each slot two cycles in.
  task automatic rx_frame(input logic [7:0] exp, input string tag);
    logic [9:0] fr;
    int cur;
    fr  = {1'b1, exp, 1'b0};
    cur = 0;
    for (int k = 0; k < 10; k++) begin
      repeat (4*k + 2 - cur) @(negedge CLK);
      cur = 4*k + 2;
      check($sformatf("%s_slot%0d", tag, k), {31'b0, TXD}, {31'b0, fr[k]});
    end
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (TXD === 1'b0) break;
      @(negedge CLK);
    end
    check({tag, "_start"}, {31'b0, TXD}, 32'h0);
  endtask

  // From the rx_frame exit point, the next contiguous start bit is two negedges away.
  task automatic next_contig(input string tag);
    repeat (2) @(negedge CLK);
    check({tag, "_contig"}, {31'b0, TXD}, 32'h0);
  endtask

  task automatic idle_hold(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (TXD !== 1'b1) bad++;
      @(negedge CLK);
    end
    check(tag, bad, 0);
  endtask

  initial begin
    // Reset and idle line
    repeat (2) @(negedge CLK);
    check("txd_in_reset", {31'b0, TXD}, 32'h1);
    RESET = 1'b1;
    @(negedge CLK);
    rd("status_reset", 4'h4, 32'h0000_0004);
    idle_hold("idle_50", 50);

    // Single byte: latency, bit order, frame length
    wr(4'h0, 32'h0000_00A5);
    check("latency_hi", {31'b0, TXD}, 32'h1);
    @(negedge CLK);
    check("latency_lo", {31'b0, TXD}, 32'h0);
    rx_frame(8'hA5, "a5");
    @(negedge CLK);
    rd("a5_busy_end", 4'h4, 32'h0000_0005);
    rd("a5_idle", 4'h4, 32'h0000_0004);

    // Five consecutive writes, contiguous frames
    fork
      begin
        for (int i = 0; i < 5; i++) wr(4'h0, 32'h11 + i);
        rd("five_status", 4'h4, 32'h0000_0043);
      end
      begin
        wait_start("five");
        rx_frame(8'h11, "b11");
      end
    join
    for (int i = 1; i < 5; i++) begin
      next_contig($sformatf("b%0h", 8'h11 + i));
      rx_frame(8'(8'h11 + i), $sformatf("b%0h", 8'h11 + i));
    end
    repeat (2) @(negedge CLK);
    rd("five_idle", 4'h4, 32'h0000_0004);

    // Overflow while a frame is in flight
    wr(4'h0, 32'h0000_003C);
    @(negedge CLK);
    check("ovf_start", {31'b0, TXD}, 32'h0);
    fork
      rx_frame(8'h3C, "inflight");
      begin
        for (int i = 0; i < 6; i++) wr(4'h0, 32'h61 + i);
        rd("ovf_status", 4'h4, 32'h0000_004B);
        wr(4'h4, 32'h0000_0008);
        rd("ovf_cleared", 4'h4, 32'h0000_0043);
      end
    join
    for (int i = 0; i < 4; i++) begin
      next_contig($sformatf("q%0h", 8'h61 + i));
      rx_frame(8'(8'h61 + i), $sformatf("q%0h", 8'h61 + i));
    end
    repeat (2) @(negedge CLK);
    rd("ovf_idle", 4'h4, 32'h0000_0004);
    idle_hold("no_dropped_bytes", 60);

    // Reset mid-frame
    wr(4'h0, 32'h0000_00A5);
    wait_start("rst");
    wr(4'h0, 32'h0000_0077);
    wr(4'h0, 32'h0000_0078);
    repeat (14) @(negedge CLK);
    #2;
    check("rst_pre_txd", {31'b0, TXD}, 32'h0);
    RESET = 1'b0;
    #1;
    check("rst_async_txd", {31'b0, TXD}, 32'h1);
    @(negedge CLK);
    rd("rst_status_held", 4'h4, 32'h0000_0004);
    RESET = 1'b1;
    rd("rst_status_rel", 4'h4, 32'h0000_0004);
    idle_hold("rst_queue_dropped", 60);

    // Unmapped offsets and deselected bus
    wr(4'h8, 32'h0000_00FF);
    rd("rd_off8", 4'h8, 32'h0);
    rd("rd_data", 4'h0, 32'h0);
    rd("rd_offc", 4'hC, 32'h0);
    rd("off8_no_push", 4'h4, 32'h0000_0004);
    io_sel = 1'b0;
    io_addr = 4'h4;
    #1;
    check("nosel_status", io_rdata, 32'h0);
    io_addr = 4'h0;
    #1;
    check("nosel_data", io_rdata, 32'h0);
    idle_hold("off8_idle", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter peripheral on the SOC's IO bus, downstream of the processor core. Stores processor writes to its data register in a small FIFO and serialises them on a single TXD pin as 8N1 frames. Gives programs a byte-stream output channel alongside the LED register, for the bench and for the board. A status register lets software poll occupancy and detect dropped bytes.

## Interface
- CLK_FREQ_HZ, 16000000: frequency of CLK in Hz.
- BAUD, 115200: line rate. DIV = CLK_FREQ_HZ / BAUD (integer, must be ≥ 2), in CLK cycles per bit.
- FIFO_DEPTH, 4: byte entries. Must be a power of two, ≥ 2.

- CLK  in  1  clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- io_sel  in  1  bus access targets this peripheral this cycle.
- io_wr  in  1  1 = write, 0 = read; meaningful only when io_sel=1.
- io_addr  in  4  byte offset. Bits [3:2] decoded; 0x0 = DATA, 0x4 = STATUS. Other offsets read 0 and ignore writes.
- io_wdata  in  32  write data.
- io_rdata  out  32  read data, combinational from current state. Driven 0 when io_sel=0.
- TXD  out  1  serial line, idle high.

## Operation
- DATA write: pushes io_wdata[7:0] into the FIFO. Reading DATA returns 0.
- STATUS read:
  - bit0 busy (state ≠ IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow (sticky)
  - bits[7:4] FIFO count
  - other bits 0
- STATUS write with io_wdata[3]=1 clears overflow.
- DATA write while full: byte dropped, overflow set. Full is sampled before any same-cycle pop, so a write in the cycle that also pops a full FIFO is still dropped.
- Overflow set and clear in the same cycle: set wins.
- Transmit FSM states IDLE, START, DATA, STOP. Baud counter counts 0..DIV-1 in each bit slot; the bit index runs 0..7 in DATA.
  - IDLE with FIFO non-empty: pop head into the shift register, go to START, clear the baud counter.
  - START: TXD=0 for DIV cycles, then go to DATA.
  - DATA: TXD = shift[0], LSB first. Shift right after each DIV cycles. After bit 7, go to STOP.
  - STOP: TXD=1 for DIV cycles. At the end of the slot, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- TXD is registered and is a function of state and shift register only.

## Timing
- Reset values:
  - TXD=1
  - state=IDLE
  - FIFO empty, count 0
  - overflow 0
  - baud counter and bit index 0
  - io_rdata follows from state, so STATUS reads 0x4.
- The reset value of the shift register is irrelevant to outputs.
- RESET asserted mid-frame: TXD=1 immediately (asynchronous), FIFO contents discarded, frame truncated.
- Write-to-line latency: write accepted at edge E. FIFO becomes non-empty after E. IDLE pops at E+1. TXD falls at E+1 and is visible in the cycle following E+1.
- Frame length is exactly 10·DIV cycles. Back-to-back frames are contiguous.
- Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits, so count = FIFO_DEPTH is representable.
- io_rdata reflects state before the current edge. A STATUS read in the same cycle as a DATA write shows the pre-write count.

## Structure
- Package io_uart_pkg holds:
  - register offsets (DATA_OFF, STATUS_OFF)
  - STATUS bit positions
  - FSM state encoding (2-bit enum: IDLE, START, DATA, STOP)
- Sub-module sync_fifo: parameterised width and depth, with push, pop, dout (head), full, empty and count. Reset is asynchronous, active-low. This module is reusable for a future RX path.
- The top module holds the bus decode, overflow flag, baud counter and transmit FSM.

## Test plan
All scenarios use CLK_FREQ_HZ=16, BAUD=4 (DIV=4), FIFO_DEPTH=4.
- Reset, then read STATUS → 0x00000004 and TXD=1 held for 50 cycles.
- Write DATA 0xA5 → TXD falls 1 cycle after the write edge. Sampling each bit mid-slot gives 0, then 1,0,1,0,0,1,0,1, then 1. Frame is 40 cycles long, then busy=0.
- Five DATA writes 0x11..0x15 on consecutive cycles → first byte popped, 4 queued, no overflow. All five frames are emitted contiguously over 200 cycles, in order.
- With the FSM stalled mid-frame, six writes into an empty FIFO → STATUS shows full=1, overflow=1, count=4. Only 4 queued bytes plus the in-flight byte appear on TXD. Writing STATUS 0x8 clears overflow.
- Assert RESET at cycle 17 of a frame → TXD=1 without waiting for an edge. STATUS = 0x4 after release. Queued bytes are never transmitted.
- Write to offset 0x8 and read offsets 0x8/0x0 → no FIFO change, io_rdata=0. With io_sel=0, io_rdata=0 regardless of io_addr.
